data_mem_arbiter: RTL

//  Shares the single byte-addressed, word-wide data memory port between two requesters
//  (req0 = CPU load/store, req1 = loader/DMA). Round-robin arbitration with one access in

---
 rtl/dmarb_pkg.sv | 21 ++
 rtl/data_mem_arbiter_rr_arb2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmarb_pkg.sv
// Shared types for the data memory arbiter.
// State encoding, requester ids, alignment helper.
package dmarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return |lsb;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick (combinational).
// req[1:0] in, last = previous winner; gnt_id/gnt_valid out.
module rr_arb2
  import dmarb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = ID_REQ0;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ~last;
      (req == 2'b10): gnt_id = ID_REQ1;
      (req == 2'b01): gnt_id = ID_REQ0;
      default:        gnt_id = ID_REQ0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one word-wide data memory port between req0/req1.
// Ports: reqN/weN/adrN/wdataN in, rdataN/ackN/errN out, busy, mem_* pins.
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          err1,
  output logic          busy,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  output logic          mem_mrd,
  output logic          mem_mwr,
  input  logic [DW-1:0] mem_dout
);

  state_t        state;
  logic          last;
  logic          id_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  logic          gnt_id;
  logic          gnt_valid;
  logic          xfer;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last      (last),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= ID_REQ1;
      id_q    <= ID_REQ0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            id_q    <= gnt_id;
            last    <= gnt_id;
            we_q    <= gnt_id ? we1 : we0;
            adr_q   <= gnt_id ? adr1 : adr0;
            wdata_q <= gnt_id ? wdata1 : wdata0;
            busy    <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // misaligned: skip the memory cycle, answer with err
          if (misaligned(adr_q[1:0])) begin
            state <= ST_RESP;
            if (id_q == ID_REQ1) begin
              ack1 <= 1'b1;
              err1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
              err0 <= 1'b1;
            end
          end else begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (id_q == ID_REQ1) begin
            ack1   <= 1'b1;
            rdata1 <= we_q ? '0 : mem_dout;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= we_q ? '0 : mem_dout;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // strobes gated by rst so a reset in ACCESS kills the write
  assign xfer    = (state == ST_ACCESS) && !rst;
  assign mem_mrd = xfer && !we_q;
  assign mem_mwr = xfer && we_q;
  assign mem_adr = (state == ST_GRANT || state == ST_ACCESS)
                   ? adr_q : '0;
  assign mem_din = (state == ST_ACCESS) ? wdata_q : '0;

endmodule
